vga_stream_checker: RTL and testbench

// Synthesizable, parametrised self-check of the VGA pixel stream against an expected pixel stream,

---
 rtl/vga_checker_pkg.sv | 16 +
 rtl/vga_sync_edge.sv | 28 ++
 rtl/vga_stream_checker.sv | 160 ++++++++++++++++
 tb/tb_vga_stream_checker.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_checker_pkg.sv
// Shared types and default window geometry for the VGA stream checker.
package vga_checker_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_CHECK,
    S_DONE
  } state_t;

  localparam int DEF_H_LEFT   = 160;
  localparam int DEF_H_RIGHT  = 480;
  localparam int DEF_V_TOP    = 120;
  localparam int DEF_V_BOTTOM = 360;

endpackage

// File: rtl/vga_sync_edge.sv
// Registers the active-low vertical sync and emits one-cycle rise/fall pulses
// from the registered pair (prev, cur).
module vga_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_n,
  output logic rise,
  output logic fall
);

  logic cur;
  logic prev;

  // NOTE: non-blocking assignments so prev samples the old cur, forming a true two-stage pipe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur  <= 1'b0;
      prev <= 1'b0;
    end else begin
      cur  <= sync_n;
      prev <= cur;
    end
  end

  assign rise = cur & ~prev;
  assign fall = ~cur & prev;

endmodule

// File: rtl/vga_stream_checker.sv
// Compares the VGA pixel stream against an expected stream over a window for one
// frame and reports pass/fail, mismatch count and the first failing pixel.
module vga_stream_checker
  import vga_checker_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int CHANNELS       = 3,
  parameter int COORD_W        = 10,
  parameter int H_LEFT         = DEF_H_LEFT,
  parameter int H_RIGHT        = DEF_H_RIGHT,
  parameter int V_TOP          = DEF_V_TOP,
  parameter int V_BOTTOM       = DEF_V_BOTTOM,
  parameter int MAX_MISMATCHES = 10,
  parameter int CNT_W          = 20
) (
  input  logic                       Clock_50,
  input  logic                       Resetn,
  input  logic                       Start_i,
  input  logic                       Mode_i,
  input  logic                       Vsync_n_i,
  input  logic                       Pixel_en_i,
  input  logic [COORD_W-1:0]         Pixel_X_i,
  input  logic [COORD_W-1:0]         Pixel_Y_i,
  input  logic [CHANNELS*DATA_W-1:0] Pixel_data_i,
  input  logic [CHANNELS*DATA_W-1:0] Exp_data_i,
  input  logic                       Exp_valid_i,
  output logic                       Exp_ready_o,
  output logic                       Busy_o,
  output logic                       Done_o,
  output logic                       Pass_o,
  output logic                       Abort_o,
  output logic                       Underrun_o,
  output logic [CNT_W-1:0]           Mismatch_count_o,
  output logic [CNT_W-1:0]           Pixel_count_o,
  output logic [COORD_W-1:0]         First_err_x_o,
  output logic [COORD_W-1:0]         First_err_y_o,
  output logic [CHANNELS-1:0]        First_err_mask_o
);

  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] FRAME_PIXELS = CNT_W'((H_RIGHT - H_LEFT) * (V_BOTTOM - V_TOP));
  localparam logic [CNT_W:0]   ABORT_LIMIT  = (CNT_W+1)'(MAX_MISMATCHES);

  state_t              state, state_nxt;
  logic                mode_q;
  logic                vs_rise, vs_fall;
  logic                in_win, pix_chk, hit, underrun_hit, over_limit;
  logic                start_acc, enter_done;
  logic [CHANNELS-1:0] mask;
  logic [CNT_W:0]      pop, cnt_sum, pix_sum;
  logic [CNT_W-1:0]    cnt_nxt, pix_nxt;

  vga_sync_edge u_sync (
    .clk   (Clock_50),
    .rst_n (Resetn),
    .sync_n(Vsync_n_i),
    .rise  (vs_rise),
    .fall  (vs_fall)
  );

  assign in_win = (Pixel_X_i >= COORD_W'(H_LEFT)) && (Pixel_X_i < COORD_W'(H_RIGHT)) &&
                  (Pixel_Y_i >= COORD_W'(V_TOP))  && (Pixel_Y_i < COORD_W'(V_BOTTOM));

  assign pix_chk      = (state == S_CHECK) && Pixel_en_i && in_win;
  assign Exp_ready_o  = pix_chk && Resetn;
  assign hit          = pix_chk && Exp_valid_i;
  assign underrun_hit = pix_chk && !Exp_valid_i;
  assign Busy_o       = (state == S_ARM) || (state == S_CHECK);
  assign start_acc    = (state == S_IDLE) && Start_i;

  // Channel 0 sits in the MSBs, so mask bit c maps to slice (CHANNELS-1-c).
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign mask[c] = Pixel_data_i[(CHANNELS-1-c)*DATA_W +: DATA_W] !=
                     Exp_data_i[(CHANNELS-1-c)*DATA_W +: DATA_W];
  end

  always_comb begin
    pop = '0;
    for (int c = 0; c < CHANNELS; c++) pop = pop + (CNT_W+1)'(mask[c]);
  end

  // One extra bit on each sum exposes the carry used for saturation.
  always_comb begin
    cnt_sum = {1'b0, Mismatch_count_o} + pop;
    pix_sum = {1'b0, Pixel_count_o} + (CNT_W+1)'(1);
    cnt_nxt = Mismatch_count_o;
    pix_nxt = Pixel_count_o;
    if (hit) begin
      cnt_nxt = cnt_sum[CNT_W] ? CNT_MAX : cnt_sum[CNT_W-1:0];
      pix_nxt = pix_sum[CNT_W] ? CNT_MAX : pix_sum[CNT_W-1:0];
    end
  end

  assign over_limit = !mode_q && hit && ({1'b0, cnt_nxt} > ABORT_LIMIT);

  always_ff @(posedge Clock_50) begin
    if (!Resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_acc) state_nxt = S_ARM;
      S_ARM:   if (vs_rise) state_nxt = S_CHECK;
      S_CHECK: if (vs_fall || underrun_hit || over_limit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign enter_done = (state == S_CHECK) && (state_nxt == S_DONE);

  always_ff @(posedge Clock_50) begin
    if (!Resetn) begin
      mode_q           <= 1'b0;
      Done_o           <= 1'b0;
      Pass_o           <= 1'b0;
      Abort_o          <= 1'b0;
      Underrun_o       <= 1'b0;
      Mismatch_count_o <= '0;
      Pixel_count_o    <= '0;
      First_err_x_o    <= '0;
      First_err_y_o    <= '0;
      First_err_mask_o <= '0;
    end else if (start_acc) begin
      mode_q           <= Mode_i;
      Done_o           <= 1'b0;
      Pass_o           <= 1'b0;
      Abort_o          <= 1'b0;
      Underrun_o       <= 1'b0;
      Mismatch_count_o <= '0;
      Pixel_count_o    <= '0;
      First_err_x_o    <= '0;
      First_err_y_o    <= '0;
      First_err_mask_o <= '0;
    end else begin
      if (hit) begin
        Mismatch_count_o <= cnt_nxt;
        Pixel_count_o    <= pix_nxt;
        if ((mask != '0) && (Mismatch_count_o == '0)) begin
          First_err_x_o    <= Pixel_X_i;
          First_err_y_o    <= Pixel_Y_i;
          First_err_mask_o <= mask;
        end
      end
      if (underrun_hit) begin
        Underrun_o <= 1'b1;
        Abort_o    <= 1'b1;
      end
      if (over_limit) Abort_o <= 1'b1;
      // The verdict uses this cycle's updated values so a pixel coinciding with Vsync counts.
      if (enter_done)
        Pass_o <= (cnt_nxt == '0) && !Underrun_o && !underrun_hit && (pix_nxt == FRAME_PIXELS);
      if (state == S_DONE) Done_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_stream_checker.sv
// Directed bench: a small 16x12 raster with an 8x6 checked window, a scan-order
// reference model, and a per-cycle monitor on Exp_ready_o.
module tb_vga_stream_checker;

  localparam int HL = 4, HR = 12, VT = 3, VB = 9;
  localparam int COLS = 16, ROWS = 12, WW = HR - HL;
  localparam int MAXM = 10;

  typedef struct packed {
    int cnt; int pix; int fx; int fy; int fm;
    bit underrun; bit abort; bit pass; int stop_idx;
  } res_t;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0, vsync_n = 1'b0;
  logic        pix_en = 1'b0, exp_valid = 1'b0;
  logic [9:0]  pix_x = '0, pix_y = '0;
  logic [23:0] pix_data = '0, exp_data = '0;
  logic        exp_ready, busy, done, pass, abort_f, underrun;
  logic [19:0] mis_cnt, pix_cnt;
  logic [9:0]  fe_x, fe_y;
  logic [2:0]  fe_mask;

  bit [23:0] dut_mem [ROWS][COLS];
  bit [23:0] exp_mem [ROWS][COLS];
  bit        val_mem [ROWS][COLS];

  int  n_tests = 0, n_fail = 0;
  bit  mon_en = 0, frame_live = 0;
  int  widx = -1, stop_idx = 0;
  res_t r;
  bit  early;

  always #5 clk = ~clk;

  vga_stream_checker #(
    .DATA_W(8), .CHANNELS(3), .COORD_W(10),
    .H_LEFT(HL), .H_RIGHT(HR), .V_TOP(VT), .V_BOTTOM(VB),
    .MAX_MISMATCHES(MAXM), .CNT_W(20)
  ) dut (
    .Clock_50(clk), .Resetn(rst_n), .Start_i(start), .Mode_i(mode),
    .Vsync_n_i(vsync_n), .Pixel_en_i(pix_en), .Pixel_X_i(pix_x), .Pixel_Y_i(pix_y),
    .Pixel_data_i(pix_data), .Exp_data_i(exp_data), .Exp_valid_i(exp_valid),
    .Exp_ready_o(exp_ready), .Busy_o(busy), .Done_o(done), .Pass_o(pass),
    .Abort_o(abort_f), .Underrun_o(underrun), .Mismatch_count_o(mis_cnt),
    .Pixel_count_o(pix_cnt), .First_err_x_o(fe_x), .First_err_y_o(fe_y),
    .First_err_mask_o(fe_mask)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle monitor: a checked pixel is one in the window of a live frame, up to the stop point.
  always @(negedge clk) begin
    if (mon_en)
      check("exp_ready", exp_ready, pix_en && frame_live && widx >= 0 && widx <= stop_idx);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic res_t model(input bit md);
    res_t m;
    bit   stopped = 0;
    int   k = 0;
    m = '{cnt: 0, pix: 0, fx: 0, fy: 0, fm: 0, underrun: 0, abort: 0, pass: 0, stop_idx: 1 << 30};
    for (int y = VT; y < VB; y++) begin
      for (int x = HL; x < HR; x++) begin
        if (!stopped) begin
          if (!val_mem[y][x]) begin
            m.underrun = 1; m.abort = 1; stopped = 1; m.stop_idx = k;
          end else begin
            int bad = 0;
            int msk = 0;
            for (int c = 0; c < 3; c++)
              if (dut_mem[y][x][(2-c)*8 +: 8] != exp_mem[y][x][(2-c)*8 +: 8]) begin
                msk |= (1 << c);
                bad++;
              end
            if (bad != 0 && m.cnt == 0) begin m.fx = x; m.fy = y; m.fm = msk; end
            m.cnt += bad;
            m.pix++;
            if (!md && m.cnt > MAXM) begin m.abort = 1; stopped = 1; m.stop_idx = k; end
          end
        end
        k++;
      end
    end
    m.pass = (m.cnt == 0) && !m.underrun && (m.pix == WW * (VB - VT));
    return m;
  endfunction

  // Outside the window the DUT data is garbage and no expected word is offered.
  task automatic fill_clean();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        exp_mem[y][x] = {8'(x * 7 + y), 8'(y * 13), 8'(x ^ y)};
        if (x >= HL && x < HR && y >= VT && y < VB) begin
          dut_mem[y][x] = exp_mem[y][x];
          val_mem[y][x] = 1'b1;
        end else begin
          dut_mem[y][x] = ~exp_mem[y][x];
          val_mem[y][x] = 1'b0;
        end
      end
  endtask

  // Corrupt the channels in msk (bit c = channel c) of window pixel w.
  task automatic corrupt(input int w, input bit [2:0] msk);
    int x = HL + w % WW;
    int y = VT + w / WW;
    for (int c = 0; c < 3; c++)
      if (msk[c]) dut_mem[y][x][(2-c)*8 +: 8] = ~exp_mem[y][x][(2-c)*8 +: 8];
  endtask

  task automatic arm(input bit md);
    start = 1'b1; mode = md;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_cleared", done, 0);
  endtask

  task automatic drive_frame(input int start_pos, input bit smode, input int rst_pos,
                             output bit done_before_end);
    vsync_n = 1'b0;
    repeat (4) tick();
    vsync_n = 1'b1;
    repeat (4) tick();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        int pos = y * COLS + x;
        pix_x = 10'(x); pix_y = 10'(y);
        pix_data = dut_mem[y][x]; exp_data = exp_mem[y][x]; exp_valid = val_mem[y][x];
        widx = (x >= HL && x < HR && y >= VT && y < VB) ? (y - VT) * WW + (x - HL) : -1;
        if (pos == start_pos) begin start = 1'b1; mode = smode; end
        if (pos == rst_pos) begin rst_n = 1'b0; frame_live = 0; end
        pix_en = 1'b1;
        tick();
        start = 1'b0; rst_n = 1'b1; pix_en = 1'b0; widx = -1;
        tick();
      end
    done_before_end = done;
    vsync_n = 1'b0;
  endtask

  task automatic check_results(input string tag, input res_t m);
    int n = 0;
    while (!done && n < 64) begin tick(); n++; end
    check({tag, " done"}, done, 1);
    check({tag, " pass"}, pass, m.pass);
    check({tag, " abort"}, abort_f, m.abort);
    check({tag, " underrun"}, underrun, m.underrun);
    check({tag, " mismatches"}, mis_cnt, m.cnt);
    check({tag, " pixels"}, pix_cnt, m.pix);
    check({tag, " first_x"}, fe_x, m.fx);
    check({tag, " first_y"}, fe_y, m.fy);
    check({tag, " first_mask"}, fe_mask, m.fm);
    check({tag, " busy"}, busy, 0);
  endtask

  task automatic run_checked(input string tag, input bit md, output bit done_before_end);
    arm(md);
    r = model(md);
    stop_idx = r.stop_idx;
    frame_live = 1;
    drive_frame(-1, 1'b0, -1, done_before_end);
    frame_live = 0;
    check_results(tag, r);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    mon_en = 1;
    tick();
    check("reset done", done, 0);
    check("reset pass", pass, 0);
    check("reset busy", busy, 0);
    check("reset mismatches", mis_cnt, 0);
    check("reset pixels", pix_cnt, 0);
    check("reset abort", abort_f, 0);

    // 1: identical stream
    fill_clean();
    run_checked("t1", 1'b0, early);
    check("t1 pixels literal", pix_cnt, 48);
    check("t1 pass literal", pass, 1);

    // 2: green wrong at (6,4), plus ignored garbage just outside the window edges
    fill_clean();
    corrupt(10, 3'b010);
    run_checked("t2", 1'b0, early);
    check("t2 first_x literal", fe_x, 6);
    check("t2 first_y literal", fe_y, 4);
    check("t2 mask literal", fe_mask, 3'b010);
    check("t2 count literal", mis_cnt, 1);

    // 3: four fully wrong pixels, abort mode then count-all mode
    fill_clean();
    for (int w = 10; w < 14; w++) corrupt(w, 3'b111);
    run_checked("t3a", 1'b0, early);
    check("t3a count literal", mis_cnt, 12);
    check("t3a abort literal", abort_f, 1);
    check("t3a pixels literal", pix_cnt, 14);
    check("t3a early done", early, 1);
    run_checked("t3b", 1'b1, early);
    check("t3b count literal", mis_cnt, 12);
    check("t3b abort literal", abort_f, 0);
    check("t3b early done", early, 0);

    // 3c: exactly MAX_MISMATCHES does not abort
    fill_clean();
    for (int w = 10; w < 13; w++) corrupt(w, 3'b111);
    corrupt(30, 3'b010);
    run_checked("t3c", 1'b0, early);
    check("t3c count literal", mis_cnt, 10);
    check("t3c abort literal", abort_f, 0);

    // 4: expected stream underruns at window pixel 20
    fill_clean();
    val_mem[VT + 20 / WW][HL + 20 % WW] = 1'b0;
    run_checked("t4", 1'b1, early);
    check("t4 pixels literal", pix_cnt, 20);
    check("t4 underrun literal", underrun, 1);
    check("t4 abort literal", abort_f, 1);

    // 5: Start mid-frame arms only; a Start during checking is ignored
    fill_clean();
    corrupt(1, 3'b001);
    frame_live = 0;
    drive_frame(5 * COLS, 1'b1, -1, early);
    check("t5 armed", busy, 1);
    r = model(1'b1);
    stop_idx = r.stop_idx;
    frame_live = 1;
    drive_frame(6 * COLS, 1'b0, -1, early);
    frame_live = 0;
    check_results("t5", r);
    check("t5 count literal", mis_cnt, 1);
    check("t5 first_x literal", fe_x, 5);

    // 6: one-clock reset mid-frame, then a clean frame
    fill_clean();
    corrupt(2, 3'b100);
    arm(1'b0);
    stop_idx = 1 << 30;
    frame_live = 1;
    drive_frame(-1, 1'b0, 7 * COLS + 6, early);
    repeat (6) tick();
    check("t6 rst done", done, 0);
    check("t6 rst busy", busy, 0);
    check("t6 rst mismatches", mis_cnt, 0);
    check("t6 rst pixels", pix_cnt, 0);
    check("t6 rst first_x", fe_x, 0);
    check("t6 rst mask", fe_mask, 0);
    fill_clean();
    run_checked("t6 clean", 1'b0, early);
    check("t6 pass literal", pass, 1);

    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
